dvb_s2_cfg_regbank: RTL and testbench



---
 rtl/dvb_s2_cfg_regbank.sv | 158 +++++++++++++++
 tb/tb_dvb_s2_cfg_regbank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dvb_s2_cfg_regbank.sv
// Double-buffered DVB-S2 modulator config bank: the host writes a shadow bank, and a commit copies it to the active bank on a frame boundary.
// Optional macro CFG_AUTO_COMMIT_TIMEOUT_EN forces the commit after TIMEOUT_CYCLES pending cycles.
module dvb_s2_cfg_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPT_MEM_ADDR_BITS  = 10,
  parameter int NUM_REGS           = 16,
  parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUES = '0,
  parameter int TIMEOUT_CYCLES     = 1000000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        wstrb,
  input  logic                                   wen,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          wdata,
  input  logic [OPT_MEM_ADDR_BITS-1:0]           waddr,
  input  logic                                   ren,
  input  logic [OPT_MEM_ADDR_BITS-1:0]           raddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          rdata,
  input  logic                                   frame_boundary,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] cfg_active,
  output logic                                   commit_pending,
  output logic                                   commit_done
);

  localparam int W  = C_S_AXI_DATA_WIDTH;
  localparam int AW = OPT_MEM_ADDR_BITS;
  localparam int N  = NUM_REGS;
  localparam int NB = W / 8;

  logic [N-1:0][W-1:0] r_shadow;
  logic [N-1:0][W-1:0] r_active;
  logic                r_wen_p;
  logic [AW-1:0]       r_waddr_p;
  logic [W-1:0]        r_wdata_p;
  logic [NB-1:0]       r_wstrb_p;
  logic                r_pending;
  logic                r_commit_done;
  logic [7:0]          r_commit_count;
  logic [W-1:0]        r_rdata;

  logic          w_ctrl_wr;
  logic          w_discard;
  logic          w_commit_req;
  logic          w_to_hit;
  logic          w_to_flag;
  logic          w_commit_fire;
  logic [W-1:0]  w_status;
  logic [W-1:0]  w_rd_val;
  logic [W-1:0]  w_sh_rd;
  logic [W-1:0]  w_ac_rd;

  function automatic logic [W-1:0] f_merge(input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                                           input logic [NB-1:0] strb);
    logic [W-1:0] res;
    res = old_v;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      else         res[8*b +: 8] = old_v[8*b +: 8];
    end
    return res;
  endfunction

  // CTRL decode works on the delayed write; DISCARD outranks COMMIT and an edge commit.
  assign w_ctrl_wr     = r_wen_p && (r_waddr_p == AW'(N)) && r_wstrb_p[0];
  assign w_discard     = w_ctrl_wr && r_wdata_p[1];
  assign w_commit_req  = w_ctrl_wr && r_wdata_p[0] && !w_discard;
  assign w_commit_fire = r_pending && (frame_boundary || w_to_hit) && !w_discard;

`ifdef CFG_AUTO_COMMIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;
  logic          r_to_flag;

  assign w_to_hit  = r_pending && (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_to_flag = r_to_flag;

  // Pending-age counter and sticky flag for commits forced without a frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else begin
      if (r_pending && !w_commit_fire && !w_discard) r_to_cnt <= r_to_cnt + CW'(1);
      else                                           r_to_cnt <= '0;
      if (w_commit_fire && w_to_hit && !frame_boundary)  r_to_flag <= 1'b1;
      else if (w_ctrl_wr && r_wdata_p[2])                r_to_flag <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign w_to_hit  = 1'b0;
  assign w_to_flag = 1'b0;
`endif

  // Write pipeline, shadow/active banks and commit state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow       <= RESET_VALUES;
      r_active       <= RESET_VALUES;
      r_wen_p        <= 1'b0;
      r_waddr_p      <= '0;
      r_wdata_p      <= '0;
      r_wstrb_p      <= '0;
      r_pending      <= 1'b0;
      r_commit_done  <= 1'b0;
      r_commit_count <= 8'd0;
    end else begin
      r_wen_p       <= wen;
      r_waddr_p     <= waddr;
      r_wdata_p     <= wdata;
      r_wstrb_p     <= wstrb;
      r_commit_done <= w_commit_fire;
      if (w_commit_fire) begin
        r_active       <= r_shadow;
        r_pending      <= 1'b0;
        r_commit_count <= r_commit_count + 8'd1;
      end
      for (int i = 0; i < N; i++) begin
        if (r_wen_p && (r_waddr_p == AW'(i)))
          r_shadow[i] <= f_merge(r_shadow[i], r_wdata_p, r_wstrb_p);
      end
      if (w_commit_req) r_pending <= 1'b1;
      if (w_discard) begin
        r_shadow  <= r_active;
        r_pending <= 1'b0;
      end
    end
  end

  assign w_status = {{(W-16){1'b0}}, r_commit_count, 6'b000000, w_to_flag, r_pending};

  // Read address decode
  always_comb begin
    w_sh_rd = '0;
    w_ac_rd = '0;
    for (int i = 0; i < N; i++) begin
      w_sh_rd = w_sh_rd | ((raddr == AW'(i))       ? r_shadow[i] : '0);
      w_ac_rd = w_ac_rd | ((raddr == AW'(N + 2 + i)) ? r_active[i] : '0);
    end
    if (raddr < AW'(N))                                   w_rd_val = w_sh_rd;
    else if (raddr == AW'(N))                             w_rd_val = '0;
    else if (raddr == AW'(N + 1))                         w_rd_val = w_status;
    else if (raddr <= AW'(2 * N + 1))                     w_rd_val = w_ac_rd;
    else w_rd_val = {16'hE000, {(W-16-AW){1'b0}}, raddr};
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rst)      r_rdata <= '0;
    else if (ren) r_rdata <= w_rd_val;
  end

  assign rdata          = r_rdata;
  assign cfg_active     = r_active;
  assign commit_pending = r_pending;
  assign commit_done    = r_commit_done;

endmodule

// File: tb/tb_dvb_s2_cfg_regbank.sv
// Self-checking bench for dvb_s2_cfg_regbank: directed scenarios plus random host traffic against a transaction-level model.
module tb_dvb_s2_cfg_regbank;
  localparam int W  = 32;
  localparam int AW = 10;
  localparam int N  = 16;
  localparam logic [N*W-1:0] RV = ({{(N*W-32){1'b0}}, 32'd2} << (4*W)) | ({{(N*W-32){1'b0}}, 32'd6} << W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    wstrb = 4'h0;
  logic          wen = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [AW-1:0] waddr = '0;
  logic          ren = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic [W-1:0]  rdata;
  logic          frame_boundary = 1'b0;
  logic [N*W-1:0] cfg_active;
  logic          commit_pending;
  logic          commit_done;

  dvb_s2_cfg_regbank #(.C_S_AXI_DATA_WIDTH(W), .OPT_MEM_ADDR_BITS(AW), .NUM_REGS(N),
                       .RESET_VALUES(RV), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .wstrb(wstrb), .wen(wen), .wdata(wdata), .waddr(waddr),
    .ren(ren), .raddr(raddr), .rdata(rdata), .frame_boundary(frame_boundary),
    .cfg_active(cfg_active), .commit_pending(commit_pending), .commit_done(commit_done));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_sh [N];
  logic [W-1:0] m_ac [N];
  bit           m_pend = 1'b0;
  int           m_cnt  = 0;
  bit           m_toflag = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
    if (a < N)      return m_sh[a];
    if (a == N)     return '0;
    if (a == N + 1) return {16'h0000, 8'(m_cnt), 6'b000000, m_toflag, m_pend};
    if (a <= 2*N+1) return m_ac[a - N - 2];
    return {16'hE000, 6'b000000, a};
  endfunction

  task automatic model_commit();
    m_ac   = m_sh;
    m_pend = 1'b0;
    m_cnt  = (m_cnt + 1) % 256;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input string tag);
    ren = 1'b1; raddr = a;
    @(posedge clk); #1;
    ren = 1'b0;
    check(tag, rdata, m_read(a));
  endtask

  // Host write; fb raises frame_boundary on the edge where the write takes effect.
  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] s, input bit fb);
    bit fire;
    wen = 1'b1; waddr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    wen = 1'b0; frame_boundary = fb;
    @(posedge clk); #1;
    frame_boundary = 1'b0;
    fire = fb && m_pend && !(a == N && s[0] && d[1]);
    if (fire) model_commit();
    if (a < N) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_sh[a][8*b +: 8] = d[8*b +: 8];
    end else if (a == N && s[0]) begin
      if (d[1]) begin m_sh = m_ac; m_pend = 1'b0; end
      else if (d[0]) m_pend = 1'b1;
    end
    check("done_after_wr", {31'd0, commit_done}, {31'd0, fire});
  endtask

  task automatic do_boundary(input string tag);
    bit fire;
    fire = m_pend;
    frame_boundary = 1'b1;
    @(posedge clk); #1;
    frame_boundary = 1'b0;
    if (fire) model_commit();
    check(tag, {31'd0, commit_done}, {31'd0, fire});
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < N; i++) check(tag, cfg_active[i*W +: W], m_ac[i]);
    check({tag, "_pend"}, {31'd0, commit_pending}, {31'd0, m_pend});
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_sh[i] = RV[i*W +: W];
      m_ac[i] = RV[i*W +: W];
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_rdata", rdata, 32'h0);
    check("rst_done", {31'd0, commit_done}, 32'd0);
    check_bank("rst_bank");
    do_read(AW'(N + 3), "rst_active1");
    check("rst_active1_const", rdata, 32'h6);
    do_read(AW'(4), "rst_shadow4");
    check("rst_shadow4_const", rdata, 32'h2);
    do_read(AW'(N + 1), "rst_status");
    do_read(10'h3FF, "unmapped");
    check("unmapped_const", rdata, 32'hE00003FF);

    do_write(AW'(0), 32'h11223344, 4'hF, 1'b0);
    do_write(AW'(0), 32'hAABBCCDD, 4'h5, 1'b0);
    do_read(AW'(0), "strb_reg0");
    check("strb_reg0_const", rdata, 32'h11BB33DD);
    do_read(AW'(N + 2), "strb_active0");

    do_write(AW'(6), 32'h0000_0A06, 4'hF, 1'b0);
    do_write(AW'(N), 32'h1, 4'hF, 1'b0);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      check("defer_hold6", cfg_active[6*W +: W], m_ac[6]);
    end
    check("defer_pend", {31'd0, commit_pending}, 32'd1);
    do_boundary("defer_done");
    check_bank("defer_bank");
    @(posedge clk); #1;
    check("defer_done_once", {31'd0, commit_done}, 32'd0);
    do_read(AW'(N + 1), "defer_status");
    check("defer_status_const", rdata, 32'h0100);

    do_write(AW'(1), 32'h9, 4'hF, 1'b0);
    do_write(AW'(N), 32'h1, 4'hF, 1'b0);
    do_write(AW'(N), 32'h3, 4'hF, 1'b0);
    check("discard_pend", {31'd0, commit_pending}, 32'd0);
    do_read(AW'(1), "discard_reg1");
    check("discard_reg1_const", rdata, 32'h6);
    do_boundary("discard_nocommit");
    check_bank("discard_bank");

    do_write(AW'(3), 32'hCAFE0003, 4'hF, 1'b0);
    do_write(AW'(N), 32'h1, 4'hF, 1'b1);
    check("coll_commit_pend", {31'd0, commit_pending}, 32'd1);
    check_bank("coll_commit_bank");
    do_boundary("coll_commit_next");
    check_bank("coll_commit_bank2");

    do_write(AW'(2), 32'h0000_00A2, 4'hF, 1'b0);
    do_write(AW'(N), 32'h1, 4'hF, 1'b0);
    do_write(AW'(2), 32'h0000_00B2, 4'hF, 1'b1);
    check("coll_wr_active2", cfg_active[2*W +: W], 32'h0000_00A2);
    do_read(AW'(2), "coll_wr_shadow2");
    check_bank("coll_wr_bank");

    for (int k = 0; k < 300; k++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) do_write(AW'($urandom_range(0, N - 1)), $urandom, 4'($urandom), ($urandom_range(0, 3) == 0));
      else if (op <= 6) do_write(AW'(N), 32'h1, 4'hF, ($urandom_range(0, 3) == 0));
      else if (op == 7) do_write(AW'(N), 32'h2, 4'hF, 1'b0);
      else do_boundary("rnd_done");
      check("rnd_pend", {31'd0, commit_pending}, {31'd0, m_pend});
      check("rnd_active", cfg_active[(k % N)*W +: W], m_ac[k % N]);
      do_read(AW'($urandom_range(0, 2*N + 5)), "rnd_read");
    end
    check_bank("rnd_bank");

    while (m_cnt != 255) begin
      do_write(AW'(N), 32'h1, 4'hF, 1'b0);
      do_boundary("wrap_done");
    end
    do_read(AW'(N + 1), "wrap_status255");
    do_write(AW'(N), 32'h1, 4'hF, 1'b0);
    do_boundary("wrap_last");
    do_read(AW'(N + 1), "wrap_status0");
    check("wrap_status0_const", rdata, 32'h0000);

    do_write(AW'(5), 32'h5555_0005, 4'hF, 1'b0);
    do_write(AW'(N), 32'h1, 4'hF, 1'b0);
`ifdef CFG_AUTO_COMMIT_TIMEOUT_EN
    repeat (99) @(posedge clk);
    #1 check("to_still_pend", {31'd0, commit_pending}, 32'd1);
    @(posedge clk); #1;
    model_commit();
    m_toflag = 1'b1;
    check("to_done", {31'd0, commit_done}, 32'd1);
    check_bank("to_bank");
    do_read(AW'(N + 1), "to_status");
`else
    repeat (1000) @(posedge clk);
    #1 check("no_to_pend", {31'd0, commit_pending}, 32'd1);
    check_bank("no_to_bank");
    do_boundary("no_to_done");
    check_bank("no_to_bank2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
